// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package md_pkg;

    localparam int MD_W     = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [1:0] {
        OP_MULTU = 2'd0,
        OP_MULT  = 2'd1,
        OP_DIVU  = 2'd2,
        OP_DIV   = 2'd3
    } md_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_t;

    // Magnitude of a 32-bit operand; unsigned ops pass the raw value through.
    function automatic logic [MD_W-1:0] md_abs(input logic [MD_W-1:0] v, input logic is_signed);
        return (is_signed && v[MD_W-1]) ? (~v + MD_W'(1)) : v;
    endfunction

endpackage

// File: rtl/md_addsub.sv
// Combinational 33-bit add/subtract shared by the multiply and divide iterations.
module md_addsub
    import md_pkg::*;
(
    input  logic [MD_W:0] x,
    input  logic [MD_W:0] y,
    input  logic          sub,
    output logic [MD_W:0] res,
    output logic          co
);

    // co is the carry out for add and the borrow out for subtract.
    always_comb begin
        if (sub) begin
            {co, res} = {1'b0, x} - {1'b0, y};
        end else begin
            {co, res} = {1'b0, x} + {1'b0, y};
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Divide support is compiled in only when MD_DIV_EN is defined.
module md_sequencer
    import md_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  md_op_t          op,
    input  logic [MD_W-1:0] a,
    input  logic [MD_W-1:0] b,
    input  logic            flush,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [MD_W-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            dz,
    output logic [MD_W-1:0] hi,
    output logic [MD_W-1:0] lo
);

    md_state_t             state_reg, state_next;
    md_op_t                op_reg, op_next;
    logic [MD_W-1:0]       a_mag_reg, a_mag_next;
    logic [MD_W-1:0]       b_mag_reg, b_mag_next;
    logic                  sign_q_reg, sign_q_next;
    logic                  dz_flag_reg, dz_flag_next;
    logic [MD_W-1:0]       acc_hi_reg, acc_hi_next;
    logic [MD_W-1:0]       acc_lo_reg, acc_lo_next;
    logic [MD_CNT_W-1:0]   cnt_reg, cnt_next;
    logic [MD_W-1:0]       hi_reg, hi_next;
    logic [MD_W-1:0]       lo_reg, lo_next;
`ifdef MD_DIV_EN
    logic [MD_W-1:0]       a_raw_reg, a_raw_next;
    logic                  sign_r_reg, sign_r_next;
`endif

    logic [MD_W:0]         as_x, as_y, as_res;
    logic                  as_sub, as_co;
    logic [MD_W-1:0]       mcand_add;
    logic [2*MD_W-1:0]     prod, prod_neg;

    assign prod     = {acc_hi_reg, acc_lo_reg};
    assign prod_neg = ~prod + (2*MD_W)'(1);

    // Operand steering for the single shared adder used in ITER.
    always_comb begin
        mcand_add = acc_lo_reg[0] ? b_mag_reg : {MD_W{1'b0}};
        as_x      = {1'b0, acc_hi_reg};
        as_y      = {1'b0, mcand_add};
        as_sub    = 1'b0;
`ifdef MD_DIV_EN
        if (op_reg[1]) begin
            as_x   = {acc_hi_reg, acc_lo_reg[MD_W-1]};
            as_y   = {1'b0, b_mag_reg};
            as_sub = 1'b1;
        end
`endif
    end

    md_addsub u_addsub (
        .x   (as_x),
        .y   (as_y),
        .sub (as_sub),
        .res (as_res),
        .co  (as_co)
    );

`ifndef MD_DIV_EN
    // Without the divider the add never carries out of 33 bits.
    logic unused_as_co;
    assign unused_as_co = as_co;
`endif

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        a_mag_next   = a_mag_reg;
        b_mag_next   = b_mag_reg;
        sign_q_next  = sign_q_reg;
        dz_flag_next = dz_flag_reg;
        acc_hi_next  = acc_hi_reg;
        acc_lo_next  = acc_lo_reg;
        cnt_next     = cnt_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
`ifdef MD_DIV_EN
        a_raw_next   = a_raw_reg;
        sign_r_next  = sign_r_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (hi_we) hi_next = wdata;
                if (lo_we) lo_next = wdata;
                if (start && !flush) begin
                    op_next     = op;
                    a_mag_next  = md_abs(a, op[0]);
                    b_mag_next  = md_abs(b, op[0]);
                    sign_q_next = op[0] & (a[MD_W-1] ^ b[MD_W-1]);
`ifdef MD_DIV_EN
                    a_raw_next   = a;
                    sign_r_next  = op[0] & a[MD_W-1];
                    dz_flag_next = op[1] && (b == {MD_W{1'b0}});
                    state_next   = ST_PREP;
`else
                    dz_flag_next = op[1];
                    state_next   = op[1] ? ST_DONE : ST_PREP;
`endif
                end
            end

            ST_PREP: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    acc_hi_next = {MD_W{1'b0}};
                    acc_lo_next = a_mag_reg;
                    cnt_next    = MD_CNT_W'(ITER);
                    state_next  = ST_ITER;
                end
            end

            ST_ITER: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
`ifdef MD_DIV_EN
                    if (op_reg[1]) begin
                        // Restoring step: keep the trial only when no borrow occurred.
                        if (!as_co) begin
                            acc_hi_next = as_res[MD_W-1:0];
                            acc_lo_next = {acc_lo_reg[MD_W-2:0], 1'b1};
                        end else begin
                            acc_hi_next = {acc_hi_reg[MD_W-2:0], acc_lo_reg[MD_W-1]};
                            acc_lo_next = {acc_lo_reg[MD_W-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi_next = as_res[MD_W:1];
                        acc_lo_next = {as_res[0], acc_lo_reg[MD_W-1:1]};
                    end
`else
                    acc_hi_next = as_res[MD_W:1];
                    acc_lo_next = {as_res[0], acc_lo_reg[MD_W-1:1]};
`endif
                    cnt_next = cnt_reg - MD_CNT_W'(1);
                    if (cnt_reg == MD_CNT_W'(1)) state_next = ST_FIX;
                end
            end

            ST_FIX: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    if (op_reg == OP_MULT && sign_q_reg) begin
                        {hi_next, lo_next} = prod_neg;
                    end else begin
                        {hi_next, lo_next} = prod;
                    end
`ifdef MD_DIV_EN
                    if (op_reg[1]) begin
                        if (dz_flag_reg) begin
                            lo_next = {MD_W{1'b1}};
                            hi_next = a_raw_reg;
                        end else begin
                            lo_next = sign_q_reg ? prod_neg[MD_W-1:0] : acc_lo_reg;
                            hi_next = sign_r_reg ? (~acc_hi_reg + MD_W'(1)) : acc_hi_reg;
                        end
                    end
`endif
                    state_next = ST_DONE;
                end
            end

            ST_DONE: state_next = ST_IDLE;

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            op_reg      <= OP_MULTU;
            a_mag_reg   <= '0;
            b_mag_reg   <= '0;
            sign_q_reg  <= 1'b0;
            dz_flag_reg <= 1'b0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            cnt_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
`ifdef MD_DIV_EN
            a_raw_reg   <= '0;
            sign_r_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            a_mag_reg   <= a_mag_next;
            b_mag_reg   <= b_mag_next;
            sign_q_reg  <= sign_q_next;
            dz_flag_reg <= dz_flag_next;
            acc_hi_reg  <= acc_hi_next;
            acc_lo_reg  <= acc_lo_next;
            cnt_reg     <= cnt_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
`ifdef MD_DIV_EN
            a_raw_reg   <= a_raw_next;
            sign_r_reg  <= sign_r_next;
`endif
        end
    end

    assign busy = (state_reg == ST_PREP) || (state_reg == ST_ITER) || (state_reg == ST_FIX);
    assign done = (state_reg == ST_DONE);
    assign dz   = (state_reg == ST_DONE) && dz_flag_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed, table-driven bench for md_sequencer (both MD_DIV_EN builds).
module tb_md_sequencer;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, flush, hi_we, lo_we;
    md_op_t      op;
    logic [31:0] a, b, wdata;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_hi, model_lo;

    typedef struct {
        md_op_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        keep;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    md_sequencer #(.ITER(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input md_op_t o, input logic [31:0] va, input logic [31:0] vb,
                                input logic [31:0] vh, input logic [31:0] vl, input logic vdz,
                                input logic vkeep, input int vlat, input string vn);
        vec_t v;
        v.op = o; v.a = va; v.b = vb; v.hi = vh; v.lo = vl;
        v.dz = vdz; v.keep = vkeep; v.lat = vlat; v.name = vn;
        return v;
    endfunction

    // Starts an op in the current cycle (cycle 0) and checks timing and result.
    task automatic run_vec(input vec_t v);
        int cyc;
        int busy_bad;
        logic [31:0] eh, el;
        eh = v.keep ? model_hi : v.hi;
        el = v.keep ? model_lo : v.lo;
        op = v.op; a = v.a; b = v.b; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        busy_bad = 0;
        while (done !== 1'b1 && cyc < 60) begin
            if (busy !== 1'b1) busy_bad++;
            step();
            cyc++;
        end
        check({v.name, " latency"}, (done === 1'b1) ? cyc : 0, v.lat);
        check({v.name, " busy"}, busy_bad, 0);
        check({v.name, " busy@done"}, busy, 0);
        check({v.name, " hi"}, hi, eh);
        check({v.name, " lo"}, lo, el);
        check({v.name, " dz"}, dz, v.dz);
        $display("op %s a=%h b=%h -> hi=%h lo=%h dz=%b done@%0d", v.name, v.a, v.b, hi, lo, dz, cyc);
        model_hi = eh;
        model_lo = el;
        step();
        check({v.name, " done pulse"}, done, 0);
    endtask

    initial begin
        int done_cnt;
        int done_cyc;

        reset = 1'b1; start = 0; flush = 0; hi_we = 0; lo_we = 0;
        op = OP_MULTU; a = 0; b = 0; wdata = 0;
        model_hi = 0; model_lo = 0;

        vecs.push_back(mk(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 0, 35, "multu_max"));
        vecs.push_back(mk(OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0, 35, "mult_m3x7"));
        vecs.push_back(mk(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 0, 35, "mult_min2"));
        vecs.push_back(mk(OP_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 0, 0, 35, "multu_sh4"));
        vecs.push_back(mk(OP_MULT,  32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 0, 0, 35, "mult_5xm1"));
        vecs.push_back(mk(OP_MULT,  32'd0,        32'hFFFFFFF7, 32'h00000000, 32'h00000000, 0, 0, 35, "mult_0xm9"));
        vecs.push_back(mk(OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 0, 0, 35, "multu_2p32"));
`ifdef MD_DIV_EN
        vecs.push_back(mk(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 35, "div_m7d2"));
        vecs.push_back(mk(OP_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1, 0, 35, "divu_7d0"));
        vecs.push_back(mk(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 0, 35, "div_ovf"));
        vecs.push_back(mk(OP_DIVU,  32'd100,      32'd3,        32'h00000001, 32'd33,       0, 0, 35, "divu_100d3"));
        vecs.push_back(mk(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 0, 35, "div_7dm2"));
        vecs.push_back(mk(OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 0, 0, 35, "divu_sh4"));
        vecs.push_back(mk(OP_DIVU,  32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h00000001, 0, 0, 35, "divu_big"));
        vecs.push_back(mk(OP_DIV,   32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF, 1, 0, 35, "div_m100d0"));
`else
        vecs.push_back(mk(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,        32'h0,        1, 1, 1,  "div_off"));
        vecs.push_back(mk(OP_DIVU,  32'd7,        32'd0,        32'h0,        32'h0,        1, 1, 1,  "divu_off"));
`endif

        // Reset values while reset is held.
        step();
        step();
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst dz", dz, 0);
        check("rst hi", hi, 0);
        check("rst lo", lo, 0);
        reset = 1'b0;
        step();

        // MTLO in IDLE is visible the next cycle.
        lo_we = 1'b1; wdata = 32'h55;
        step();
        lo_we = 1'b0;
        check("mtlo lo", lo, 32'h55);
        check("mtlo hi", hi, 0);
        model_lo = 32'h55;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Starts in ITER/DONE ignored, MTHI during ITER dropped, MTHI with start written.
        op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1; hi_we = 1'b1; wdata = 32'hABCD;
        step();
        start = 1'b0; hi_we = 1'b0;
        check("mthi+start hi", hi, 32'hABCD);
        done_cnt = 0;
        done_cyc = 0;
        for (int c = 1; c <= 75; c++) begin
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            start = (c == 5 || c == 35);
            a = 32'd3; b = 32'd3;
            hi_we = (c == 10);
            wdata = 32'h1234;
            step();
        end
        start = 1'b0; hi_we = 1'b0;
        check("restart done count", done_cnt, 1);
        check("restart done cycle", done_cyc, 35);
        check("restart hi", hi, 32'h0);
        check("restart lo", lo, 32'd42);
        $display("op ignore_starts a=6 b=7 -> hi=%h lo=%h dones=%0d", hi, lo, done_cnt);
        model_hi = 0;
        model_lo = 32'd42;

        // Flush in the middle of an op, then restart immediately.
`ifdef MD_DIV_EN
        op = OP_DIVU;
`else
        op = OP_MULTU;
`endif
        a = 32'd100; b = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 20; c++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush busy", busy, 0);
        check("flush done", done, 0);
        check("flush hi", hi, model_hi);
        check("flush lo", lo, model_lo);
        $display("op flush@20 -> hi=%h lo=%h busy=%b", hi, lo, busy);
`ifdef MD_DIV_EN
        run_vec(mk(OP_DIVU, 32'd100, 32'd3, 32'd1, 32'd33, 0, 0, 35, "after_flush"));
`else
        run_vec(mk(OP_MULTU, 32'd100, 32'd3, 32'd0, 32'd300, 0, 0, 35, "after_flush"));
`endif

        // Flush beats start in the same IDLE cycle.
        op = OP_MULTU; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        check("flush+start busy", busy, 0);
        check("flush+start done", done, 0);
        $display("op flush_vs_start -> busy=%b done=%b", busy, done);

        // Asynchronous reset in the middle of a multiply.
        op = OP_MULT; a = 32'hFFFFFFFD; b = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        #2 reset = 1'b1;
        #1;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst dz", dz, 0);
        check("midrst hi", hi, 0);
        check("midrst lo", lo, 0);
        $display("op reset@10 -> busy=%b hi=%h lo=%h", busy, hi, lo);
        step();
        reset = 1'b0;
        model_hi = 0;
        model_lo = 0;
        step();
        run_vec(mk(OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0, 35, "after_reset"));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
